vram_bus_arbiter: RTL

Sits directly downstream of the ISA write buffer and owns the external VRAM bus. It arbitrates between write-buffer drains and scanout/readback reads, drives the write buffer's `free` input, and multiplexes address, data and strobes onto the single VRAM port. Reads take priority, but three mechanisms stop the write buffer from starving: a burst limit, a forced write window, and the write buffer's almost-full flag.

---
 rtl/vram_bus_arbiter_pkg.sv | 20 ++
 rtl/vram_bus_arbiter_if.sv | 39 +++
 rtl/vram_bus_arbiter_wait_counter.sv | 27 ++
 rtl/vram_bus_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vram_bus_arbiter_pkg.sv
// Shared types and widths for the VRAM bus arbiter slice.
package vram_bus_arbiter_pkg;

    localparam int unsigned VRAM_ADDR_W = 20;
    localparam int unsigned VRAM_DATA_W = 16;
    localparam int unsigned CTR_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_ADDR,
        RD_WAIT,
        RD_DONE
    } arb_state_t;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == '1) ? v : v + CTR_W'(1);
    endfunction

endpackage

// File: rtl/vram_bus_arbiter_if.sv
// Read requester, write buffer and VRAM pin bundle seen by the arbiter.
interface vram_bus_arbiter_if;
    import vram_bus_arbiter_pkg::*;

    logic                   rd_req;
    logic [VRAM_ADDR_W-1:0] rd_addr;
    logic                   rd_ack;
    logic [VRAM_DATA_W-1:0] rd_data;
    logic                   rd_valid;
    logic                   wb_free;
    logic                   wb_io_en;
    logic                   wb_we_n;
    logic                   wb_ce_n;
    logic [VRAM_ADDR_W-1:0] wb_addr;
    logic [VRAM_DATA_W-1:0] wb_data;
    logic                   wb_almost_full;
    logic [VRAM_ADDR_W-1:0] vram_addr;
    logic [VRAM_DATA_W-1:0] vram_dout;
    logic [VRAM_DATA_W-1:0] vram_din;
    logic                   vram_dout_en;
    logic                   vram_ce_n;
    logic                   vram_we_n;
    logic                   vram_oe_n;

    modport master (
        input  rd_req, rd_addr, wb_io_en, wb_we_n, wb_ce_n, wb_addr, wb_data,
               wb_almost_full, vram_din,
        output rd_ack, rd_data, rd_valid, wb_free, vram_addr, vram_dout,
               vram_dout_en, vram_ce_n, vram_we_n, vram_oe_n
    );

    modport slave (
        output rd_req, rd_addr, wb_io_en, wb_we_n, wb_ce_n, wb_addr, wb_data,
               wb_almost_full, vram_din,
        input  rd_ack, rd_data, rd_valid, wb_free, vram_addr, vram_dout,
               vram_dout_en, vram_ce_n, vram_we_n, vram_oe_n
    );

endinterface

// File: rtl/vram_bus_arbiter_wait_counter.sv
// Loadable down-counter that stops at zero; zero flag is combinational.
module vram_wait_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vram_bus_arbiter.sv
// Owns the VRAM port: write-buffer drains versus prioritised reads, with
// burst limit and post-burst write window to keep the write buffer moving.
module vram_bus_arbiter
    import vram_bus_arbiter_pkg::*;
#(
    parameter int unsigned READ_WAIT    = 1,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned WRITE_WINDOW = 4
) (
    input  logic               clock,
    input  logic               RESET,
    vram_bus_arbiter_if.master bus
);

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
    localparam logic [CTR_W-1:0] BURST_MAX = CTR_W'(MAX_BURST);
    localparam logic [CTR_W-1:0] WIN_LOAD  = CTR_W'(WRITE_WINDOW);

    arb_state_t             state;
    logic                   out_of_reset;
    logic                   drain_first;
    logic [CTR_W-1:0]       burst_ctr;
    logic [VRAM_ADDR_W-1:0] rd_addr_q;
    logic [VRAM_ADDR_W-1:0] addr_r;
    logic                   ce_n_r;
    logic                   oe_n_r;
    logic                   rd_ack_r;
    logic                   rd_valid_r;
    logic [VRAM_DATA_W-1:0] rd_data_r;
    logic                   wb_free_r;
    logic                   wait_zero;
    logic                   win_zero;
    logic                   wb_path;

    vram_wait_counter #(.WIDTH(CTR_W)) u_wait_ctr (
        .clock    (clock),
        .RESET    (RESET),
        .load     (state == RD_ADDR),
        .load_val (WAIT_LOAD),
        .dec      (state == RD_WAIT),
        .zero     (wait_zero)
    );

    // Loaded only when leaving a burst with the write buffer nearly full.
    vram_wait_counter #(.WIDTH(CTR_W)) u_win_ctr (
        .clock    (clock),
        .RESET    (RESET),
        .load     ((state == RD_DONE) && bus.wb_almost_full),
        .load_val (WIN_LOAD),
        .dec      (state == IDLE),
        .zero     (win_zero)
    );

    always_ff @(posedge clock or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            out_of_reset <= 1'b0;
            drain_first  <= 1'b0;
            burst_ctr    <= '0;
            rd_addr_q    <= '0;
            addr_r       <= '0;
            ce_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
            rd_ack_r     <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= '0;
            wb_free_r    <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            rd_ack_r     <= 1'b0;
            rd_valid_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_req && win_zero) begin
                        state       <= DRAIN;
                        wb_free_r   <= 1'b0;
                        rd_addr_q   <= bus.rd_addr;
                        drain_first <= 1'b1;
                    end else begin
                        wb_free_r   <= 1'b1;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle always held: the buffer may launch one more write.
                    drain_first <= 1'b0;
                    if (!drain_first && !bus.wb_io_en) begin
                        state    <= RD_ADDR;
                        addr_r   <= rd_addr_q;
                        ce_n_r   <= 1'b0;
                        oe_n_r   <= 1'b0;
                        rd_ack_r <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    burst_ctr <= sat_inc(burst_ctr);
                    state     <= (READ_WAIT > 0) ? RD_WAIT : RD_DONE;
                end
                RD_WAIT: begin
                    if (wait_zero) state <= RD_DONE;
                end
                RD_DONE: begin
                    rd_data_r  <= bus.vram_din;
                    rd_valid_r <= 1'b1;
                    if (bus.rd_req && (burst_ctr < BURST_MAX) && !bus.wb_almost_full) begin
                        state    <= RD_ADDR;
                        addr_r   <= bus.rd_addr;
                        rd_ack_r <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        burst_ctr <= '0;
                        ce_n_r    <= 1'b1;
                        oe_n_r    <= 1'b1;
                        wb_free_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // out_of_reset keeps the pins parked while RESET is low even though state is IDLE.
    assign wb_path = out_of_reset && ((state == IDLE) || (state == DRAIN));

    always_comb begin
        bus.vram_addr    = addr_r;
        bus.vram_dout    = '0;
        bus.vram_we_n    = 1'b1;
        bus.vram_ce_n    = ce_n_r;
        bus.vram_oe_n    = oe_n_r;
        bus.vram_dout_en = 1'b0;
        if (wb_path) begin
            bus.vram_addr    = bus.wb_addr;
            bus.vram_dout    = bus.wb_data;
            bus.vram_we_n    = bus.wb_we_n;
            bus.vram_ce_n    = bus.wb_ce_n;
            bus.vram_oe_n    = 1'b1;
            bus.vram_dout_en = bus.wb_io_en;
        end
    end

    assign bus.rd_ack   = rd_ack_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.wb_free  = wb_free_r;

endmodule
